// File: rtl/frame_row_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Constants and types shared by the frame row reader and the
//                writer-side row buffer (geometry, FSM state, row tag).
//  Revision    : 1.0  initial release
// ============================================================================
package frame_pkg;

    localparam int ROW_W    = 640;
    localparam int NUM_ROWS = 480;
    localparam int ADDR_W   = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Tag carried alongside each row through the skid FIFO.
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic              last;
    } row_tag_t;

    localparam int ENTRY_W = ROW_W + $bits(row_tag_t);

endpackage
`default_nettype wire

// File: rtl/frame_row_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_row_reader_if
//  Description : Bundle of the reader's control, buffer-read and output
//                stream signals.
//                master : the reader (drives rd_addr, row_*, busy, done)
//                slave  : the environment (start, frame_full, rd_data,
//                         row_ready)
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_row_reader_if import frame_pkg::*; #(
    parameter int ROW_W  = frame_pkg::ROW_W,
    parameter int ADDR_W = frame_pkg::ADDR_W
);
    logic              start;
    logic              frame_full;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  rd_data;
    logic [ROW_W-1:0]  row_data;
    logic [ADDR_W-1:0] row_idx;
    logic              row_last;
    logic              row_valid;
    logic              row_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, frame_full, rd_data, row_ready,
        output rd_addr, row_data, row_idx, row_last, row_valid, busy, done
    );

    modport slave (
        output start, frame_full, rd_data, row_ready,
        input  rd_addr, row_data, row_idx, row_last, row_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/frame_row_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : row_skid_fifo
//  Description : 2-entry FIFO absorbing rows returned by the buffer while the
//                downstream stream is stalled.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                push_i/push_data_i   write an entry
//                pop_i           consume the head entry
//                head_o          head entry (meaningful when count_o != 0)
//                count_o         occupancy 0..2
//  Revision    : 1.0  initial release
// ============================================================================
module row_skid_fifo import frame_pkg::*; #(
    parameter int WIDTH = ENTRY_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic      [1:0]       count_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; the write lands in the slot being vacated.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/frame_row_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_row_reader
//  Description : Read-side sequencer for the frame row buffer. Once the
//                buffer is full and start is seen, every row is read once,
//                the buffer's 1-cycle read latency is absorbed by a 2-entry
//                skid FIFO, and rows are streamed out on valid/ready.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                bus        frame_row_reader_if.master:
//                  start, frame_full   scan request / buffer full flag
//                  rd_addr, rd_data    buffer read port (1-cycle latency)
//                  row_data, row_idx, row_last, row_valid, row_ready
//                                      output row stream
//                  busy, done          scan status / completion pulse
//  Options     : FRAME_READER_REVERSE_EN - scan rows bottom-up (479..0)
//  Revision    : 1.0  initial release
// ============================================================================
module frame_row_reader import frame_pkg::*; #(
    parameter int ROW_W    = frame_pkg::ROW_W,
    parameter int NUM_ROWS = frame_pkg::NUM_ROWS,
    parameter int ADDR_W   = frame_pkg::ADDR_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    frame_row_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] ROW_ONE = ADDR_W'(1);
`ifdef FRAME_READER_REVERSE_EN
    localparam logic [ADDR_W-1:0] FIRST_ROW = ADDR_W'(NUM_ROWS - 1);
    localparam logic [ADDR_W-1:0] FINAL_ROW = ADDR_W'(0);
`else
    localparam logic [ADDR_W-1:0] FIRST_ROW = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] FINAL_ROW = ADDR_W'(NUM_ROWS - 1);
`endif

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              inflight_q;
    row_tag_t          tag_q;
    logic              busy_q;
    logic              done_q;

    logic [1:0]        fifo_count;
    logic [ROW_W+$bits(row_tag_t)-1:0] fifo_head;
    logic [ROW_W-1:0]  head_data;
    row_tag_t          head_tag;
    logic              row_valid;
    logic              pop;
    logic              issue;
    logic [2:0]        credit;
    logic              drained;

    assign row_valid = (fifo_count != 2'd0);
    assign pop       = row_valid & bus.row_ready;

    // Rows the FIFO will have to hold after this cycle if nothing new is
    // issued; a new read is allowed only while this stays below capacity.
    assign credit = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue  = (state_q == SCAN) && (credit < 3'd2);

    // The address is presented in the issue cycle itself so the buffer
    // captures it at the next edge; otherwise the previous address is held.
    assign rd_addr_d   = issue ? cnt_q : rd_addr_q;
    assign bus.rd_addr = rd_addr_d;

    // Frame complete once the final row leaves the FIFO and nothing is
    // still returning from the buffer.
    assign drained = !inflight_q &&
                     ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            inflight_q <= issue;
            done_q     <= 1'b0;
            if (issue) begin
                tag_q <= '{idx: cnt_q, last: (cnt_q == FINAL_ROW)};
            end
            case (state_q)
                IDLE: begin
                    if (bus.start && bus.frame_full) begin
                        state_q <= SCAN;
                        cnt_q   <= FIRST_ROW;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (cnt_q == FINAL_ROW) begin
                            state_q <= DRAIN;
                        end else begin
`ifdef FRAME_READER_REVERSE_EN
                            cnt_q <= cnt_q - ROW_ONE;
`else
                            cnt_q <= cnt_q + ROW_ONE;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    row_skid_fifo #(
        .WIDTH(ROW_W + $bits(row_tag_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i ({bus.rd_data, tag_q}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign {head_data, head_tag} = fifo_head;

    // Outputs read as zero whenever no row is presented.
    assign bus.row_valid = row_valid;
    assign bus.row_data  = row_valid ? head_data     : '0;
    assign bus.row_idx   = row_valid ? head_tag.idx  : '0;
    assign bus.row_last  = row_valid & head_tag.last;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_row_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_row_reader
//  Description : Self-checking bench for frame_row_reader with a behavioural
//                1-cycle-latency row buffer (row k = {k[0], 71 copies of k}).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_row_reader;
    import frame_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_row_reader_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

    frame_row_reader u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [ROW_W-1:0] pat(input logic [ADDR_W-1:0] k);
        return {k[0], {71{k}}};
    endfunction

    // Row index presented at position n of the scan.
    function automatic logic [ADDR_W-1:0] seq(input int n);
`ifdef FRAME_READER_REVERSE_EN
        return ADDR_W'(NUM_ROWS - 1 - n);
`else
        return ADDR_W'(n);
`endif
    endfunction

    // Row buffer: registers the address, data appears next cycle.
    always @(posedge clk) bus.rd_data <= pat(bus.rd_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, bus.row_valid, 0);
        chk({nm, "_busy"},  bus.busy, 0);
        chk({nm, "_done"},  bus.done, 0);
        chk({nm, "_addr"},  bus.rd_addr, 0);
        chk({nm, "_idx"},   bus.row_idx, 0);
        chk({nm, "_last"},  bus.row_last, 0);
        chk({nm, "_data"},  (bus.row_data == '0), 1);
    endtask

    typedef struct {
        logic start;
        logic full;
        logic ready;
        logic exp_busy;
        logic exp_valid;
        int   exp_ord;     // scan position of the presented row
        logic addr_ord;    // 1: rd_addr is seq(exp_addr); 0: literal value
        int   exp_addr;
    } vec_t;

    // One frame scan. rnd: 30% ready duty; stall_at: hold ready low for 50
    // cycles once that many rows are accepted; rst_at: reset the DUT once
    // that many rows are accepted.
    task automatic run_frame(input bit rnd, input int stall_at, input int rst_at);
        int n = 0;
        int cyc = 0;
        int post = -1;
        int stall_left = 0;
        bit finished = 0;
        bit prev_vs = 0;
        logic [ADDR_W-1:0] prev_idx = '0;
        logic              prev_last = 1'b0;
        logic [ROW_W-1:0]  prev_data = '0;

        bus.start = 1'b1;
        bus.frame_full = 1'b1;
        bus.row_ready = 1'b1;
        @(negedge clk);
        chk("accept_busy_pre", bus.busy, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;

        while (!finished && cyc < 4000) begin
            if (stall_left > 0)  bus.row_ready = 1'b0;
            else if (rnd)        bus.row_ready = ($urandom_range(0, 9) < 3);
            else                 bus.row_ready = 1'b1;
            @(negedge clk);

            if (post == 1) begin
                chk("done_pulse", bus.done, 1);
                chk("fin_busy", bus.busy, 1);
                chk("fin_valid", bus.row_valid, 0);
            end else if (post == 2) begin
                chk("done_once", bus.done, 0);
                chk("idle_busy", bus.busy, 0);
                finished = 1;
            end else begin
                chk("no_early_done", bus.done, 0);
                chk("scan_busy", bus.busy, 1);
                if (cyc == 1) chk("lat_no_valid", bus.row_valid, 0);
                if (cyc == 2) chk("lat_first_valid", bus.row_valid, 1);
                if (prev_vs) begin
                    chk("hold_valid", bus.row_valid, 1);
                    chk("hold_idx", bus.row_idx, prev_idx);
                    chk("hold_last", bus.row_last, prev_last);
                    chk("hold_data", (bus.row_data == prev_data), 1);
                end
                if (stall_left > 0) begin
                    chk("stall_idx", bus.row_idx, seq(stall_at));
                    chk("stall_addr", bus.rd_addr, seq(stall_at + 1));
                    if (stall_left == 1)
                        chk("stall_fifo_cnt", u_dut.u_fifo.count_q, 2);
                    stall_left--;
                end else if (!rnd && cyc >= 2 && post < 0) begin
                    chk("no_gap", bus.row_valid, 1);
                end
                if (bus.row_valid && bus.row_ready) begin
                    chk("idx", bus.row_idx, seq(n));
                    chk("data", (bus.row_data == pat(seq(n))), 1);
                    chk("last", bus.row_last, (n == NUM_ROWS - 1));
                    n++;
                    if (n == NUM_ROWS) post = 0;
                    if (n == stall_at) stall_left = 50;
                end
                prev_vs   = bus.row_valid && !bus.row_ready;
                prev_idx  = bus.row_idx;
                prev_last = bus.row_last;
                prev_data = bus.row_data;
            end

            if (rst_at >= 0 && n == rst_at) begin
                @(posedge clk); #1;
                rst = 1'b1;
                bus.row_ready = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk_all_zero("midrst");
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("midrst_no_done", bus.done, 0);
                end
                @(posedge clk); #1;
                return;
            end

            if (post >= 0) post++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!finished) chk("frame_timeout", 0, 1);
        chk("rows_delivered", n, NUM_ROWS);
    endtask

    vec_t vt[9];

    initial begin
        //          start full ready busy valid ord  addr_ord addr
        vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 2};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 3};
        vt[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 4};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.frame_full = 1'b0;
        bus.row_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            bus.start      = vt[i].start;
            bus.frame_full = vt[i].full;
            bus.row_ready  = vt[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d_busy", i), bus.busy, vt[i].exp_busy);
            chk($sformatf("v%0d_valid", i), bus.row_valid, vt[i].exp_valid);
            chk($sformatf("v%0d_addr", i), bus.rd_addr,
                vt[i].addr_ord ? seq(vt[i].exp_addr) : ADDR_W'(vt[i].exp_addr));
            chk($sformatf("v%0d_done", i), bus.done, 0);
            if (vt[i].exp_valid) begin
                chk($sformatf("v%0d_idx", i), bus.row_idx, seq(vt[i].exp_ord));
                chk($sformatf("v%0d_data", i), (bus.row_data == pat(seq(vt[i].exp_ord))), 1);
                chk($sformatf("v%0d_last", i), bus.row_last, 0);
            end else begin
                chk($sformatf("v%0d_idx", i), bus.row_idx, 0);
                chk($sformatf("v%0d_data", i), (bus.row_data == '0), 1);
            end
            @(posedge clk); #1;
        end

        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame(1'b0, -1, -1);   // full throughput
        run_frame(1'b1, -1, -1);   // random back-pressure
        run_frame(1'b0, 100, -1);  // 50-cycle stall at row 100
        run_frame(1'b0, -1, 200);  // reset mid-scan
        run_frame(1'b0, -1, -1);   // fresh scan after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/frame_row_reader.md
Name: frame_row_reader

Overview:
- Read-side sequencer for the 640x480 frame row buffer.
- After the buffer reports full, it scans all rows out once by driving the buffer's read address, and absorbs the buffer's one-cycle read latency.
- Presents rows on a valid/ready stream to the downstream SAD datapath, with full back-pressure support.
- Completion is signalled with a done pulse; the writer may then reset and refill the buffer.

Parameters:
- ROW_W, 640: row width in bits; matches buffer data width.
- NUM_ROWS, 480: rows per frame.
- ADDR_W, 9: row address width; 2^ADDR_W must be at least NUM_ROWS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one frame scan; accepted only in IDLE with frame_full=1.
- frame_full  in  1  buffer full flag from the writer side.
- rd_addr  out  ADDR_W  read address to the buffer; buffer registers it, data appears on rd_data next cycle.
- rd_data  in  ROW_W  row data from the buffer.
- row_data  out  ROW_W  output row.
- row_idx  out  ADDR_W  row number of row_data.
- row_last  out  1  high with the final row of the frame.
- row_valid  out  1  row_data/row_idx/row_last are valid.
- row_ready  in  1  downstream accepts when valid & ready.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - State returns to IDLE.
  - rd_addr, row_data, row_idx, row_last, row_valid, busy and done are all 0.
  - Skid buffer is emptied and the in-flight counter is cleared.
  - A reset mid-scan abandons the frame; no done pulse is produced.
- State machine: IDLE -> SCAN -> DRAIN -> FIN -> IDLE.
  - IDLE: busy=0. If start & frame_full, go to SCAN; the issue counter loads 0. If start arrives with frame_full=0, it is ignored and not latched.
  - SCAN: issue one read per cycle when credit allows. After issuing row NUM_ROWS-1, go to DRAIN.
  - DRAIN: no new issues. Wait until no read is in flight and the skid buffer is empty, with the last row accepted; then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0 from the next cycle, then return to IDLE.
- Read issue:
  - Issuing row k means driving rd_addr=k in cycle t. The buffer captures it at edge t+1, and rd_data holds row k during cycle t+1.
  - The captured row is written into a 2-entry skid FIFO at the end of cycle t+1, tagged with idx=k and last=(k==NUM_ROWS-1).
  - rd_addr holds its last value when nothing is issued.
- Credit rule:
  - Issue in cycle t only if (fifo_count + inflight - pop_t) < 2, where pop_t = row_valid & row_ready.
  - The FIFO therefore never overflows and rd_data is never dropped.
  - Sustained throughput is 1 row/cycle when row_ready is held high.
- Output stream:
  - row_valid = FIFO non-empty; outputs show the FIFO head.
  - Once row_valid is high, row_data/row_idx/row_last hold stable until accepted (no retraction).
  - Rows emerge in strictly increasing row_idx order, 0..NUM_ROWS-1, exactly once each.
- Counters and widths:
  - Issue counter is ADDR_W bits and compares against NUM_ROWS-1; no wrap within a frame.
  - inflight is 0 or 1.
  - fifo_count is 2 bits, range 0..2.
- Boundary cases:
  - Simultaneous push and pop with fifo_count=2 is legal: count stays 2 and order is preserved.
  - row_ready held low for any length stalls issue after 2 rows are buffered; no data loss.
  - frame_full falling during SCAN is ignored; integrity of the source is the writer's responsibility.
  - start during SCAN, DRAIN or FIN is ignored.

Optional Feature:
- Macro: FRAME_READER_REVERSE_EN.
- When defined:
  - Scan runs bottom-up; the issue counter loads NUM_ROWS-1 and decrements.
  - row_idx follows the issued address.
  - row_last is asserted on row 0.
  - SCAN ends after issuing row 0.
- When undefined: ascending scan exactly as above.
- Credit, handshake, latency and done timing are identical in both modes.

Decomposition:
- Package frame_pkg holds:
  - Constants ROW_W=640, NUM_ROWS=480, ADDR_W=9, shared with the writer-side buffer.
  - State enum for IDLE/SCAN/DRAIN/FIN.
  - Typedef for the row tag {idx, last}.
- Sub-module row_skid_fifo: 2-entry, width ROW_W+ADDR_W+1, with push/pop/count outputs.
- The top level holds the FSM, issue counter and credit logic.

Test Plan:
- Reset then start=1 with frame_full=0: no state change, busy stays 0, rd_addr=0. Raise frame_full and pulse start: busy=1 next cycle.
- Full-throughput scan, row_ready always 1, buffer preloaded with row k = {k replicated}:
  - 480 beats on consecutive cycles, row_idx 0..479.
  - First row_valid 2 cycles after start acceptance.
  - row_last only on idx 479.
  - done pulses exactly once, 1 cycle after the last handshake.
- Random back-pressure (row_ready 30% duty): every row delivered once, in order, data matching; outputs stable while valid & !ready; FIFO count never exceeds 2.
- Stall row_ready=0 for 50 cycles at idx 100: exactly 2 rows buffered, rd_addr frozen. On release, rows 100,101,102... continue without a gap or duplicate.
- Assert rst at idx 200 mid-scan: all outputs 0 next cycle, no done pulse. A fresh start rescans from idx 0.
- FRAME_READER_REVERSE_EN defined: row_idx sequence 479..0, row_last on idx 0, done after 480 handshakes.
